// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: fetched instruction and PSR in, control strobes out.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
);
  logic [WIDTH-1:0]   instr;
  logic [7:0]         PSROut;
  logic               mem_ready;
  logic               PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData;
  logic               regWrite, ZeroExtend, PCinstruction, SrcB, shiftType;
  logic               jumpEN, BranchEN, jalEN;
  logic [REGBITS-1:0] ALUcond;
  logic [1:0]         chooseResult;
  logic               memWrite;

  modport master (
    input  instr, PSROut, mem_ready,
    output PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData,
           regWrite, ZeroExtend, PCinstruction, SrcB, shiftType,
           jumpEN, BranchEN, jalEN, ALUcond, chooseResult, memWrite
  );

  modport slave (
    output instr, PSROut, mem_ready,
    input  PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData,
           regWrite, ZeroExtend, PCinstruction, SrcB, shiftType,
           jumpEN, BranchEN, jalEN, ALUcond, chooseResult, memWrite
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle sequencing FSM for the CR16-style datapath; strobes are decoded from state and instr.
// Optional CTRL_MEM_WAIT_EN: LATCH, LOAD_WB and STORE stall until mem_ready.
module multicycle_controller #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus,
  output logic [3:0]             state_dbg
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    LATCH     = 4'd1,
    DECODE    = 4'd2,
    ALU       = 4'd3,
    SHIFT     = 4'd4,
    LOAD_ADDR = 4'd5,
    LOAD_WB   = 4'd6,
    STORE     = 4'd7,
    BRANCH    = 4'd8,
    JCOND     = 4'd9,
    JAL       = 4'd10
  } state_t;

  state_t     state_r, nextState_s;
  logic [3:0] op_s, ext_s, cond_s, aluCode_s;
  logic       isAluOp_s, condMet_s, memGo_s;
  logic       pcen_s, psren_s, nextInstr_s, regWrite_s, memWrite_s;
  logic [2:0] unusedPsrBits_s;

  function automatic logic condTrue(input logic [3:0] c, input logic [7:0] psr);
    logic cf, lf, ff, zf, nf;
    cf = psr[0];
    lf = psr[2];
    ff = psr[5];
    zf = psr[6];
    nf = psr[7];
    case (c)
      4'b0000: condTrue = zf;
      4'b0001: condTrue = ~zf;
      4'b1101: condTrue = nf | zf;
      4'b0010: condTrue = cf;
      4'b0011: condTrue = ~cf;
      4'b0100: condTrue = lf;
      4'b0101: condTrue = ~lf;
      4'b1010: condTrue = ~lf & ~zf;
      4'b1011: condTrue = lf | zf;
      4'b0110: condTrue = nf;
      4'b0111: condTrue = ~nf;
      4'b1000: condTrue = ff;
      4'b1001: condTrue = ~ff;
      4'b1100: condTrue = ~nf & ~zf;
      4'b1110: condTrue = 1'b1;
      default: condTrue = 1'b0;
    endcase
  endfunction

  assign op_s      = bus.instr[15:12];
  assign cond_s    = bus.instr[11:8];
  assign ext_s     = bus.instr[7:4];
  assign aluCode_s = (op_s == 4'b0000) ? ext_s : op_s;
  assign isAluOp_s = op_s inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101,
                                  4'b1001, 4'b1011, 4'b1101, 4'b1111};
  assign condMet_s = condTrue(cond_s, bus.PSROut);
  assign unusedPsrBits_s = {bus.PSROut[4:3], bus.PSROut[1]};

`ifdef CTRL_MEM_WAIT_EN
  assign memGo_s = bus.mem_ready;
`else
  logic unusedMemReady_s;
  assign unusedMemReady_s = bus.mem_ready;
  assign memGo_s = 1'b1;
`endif

  // State register; reset returns to FETCH and abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state and strobe decode from current state and latched instruction.
  always_comb begin
    nextState_s           = state_r;
    pcen_s                = 1'b0;
    psren_s               = 1'b0;
    nextInstr_s           = 1'b0;
    regWrite_s            = 1'b0;
    memWrite_s            = 1'b0;
    bus.updateAddress     = 1'b0;
    bus.StoreReg          = 1'b0;
    bus.WriteData         = 1'b0;
    bus.ZeroExtend        = 1'b0;
    bus.PCinstruction     = 1'b0;
    bus.SrcB              = 1'b0;
    bus.shiftType         = 1'b0;
    bus.jumpEN            = 1'b0;
    bus.BranchEN          = 1'b0;
    bus.jalEN             = 1'b0;
    bus.ALUcond           = '0;
    bus.chooseResult      = 2'b00;
    case (state_r)
      FETCH: begin
        bus.updateAddress = 1'b1;
        nextState_s       = LATCH;
      end
      LATCH: begin
        bus.updateAddress = 1'b1;
        if (memGo_s) begin
          nextInstr_s = 1'b1;
          nextState_s = DECODE;
        end else begin
          nextState_s = LATCH;
        end
      end
      DECODE: begin
        case (op_s)
          4'b1000: nextState_s = SHIFT;
          4'b1100: nextState_s = BRANCH;
          4'b0100: begin
            case (ext_s)
              4'b0000: nextState_s = LOAD_ADDR;
              4'b0100: nextState_s = STORE;
              4'b1100: nextState_s = JCOND;
              4'b1000: nextState_s = JAL;
              default: nextState_s = ALU;
            endcase
          end
          default: nextState_s = ALU;
        endcase
      end
      ALU: begin
        // Unrecognised encodings land here too; isAluOp_s keeps them from writing back.
        bus.ALUcond      = REGBITS'(aluCode_s);
        bus.SrcB         = (op_s == 4'b0000);
        bus.ZeroExtend   = op_s inside {4'b0001, 4'b0010, 4'b0011};
        bus.chooseResult = 2'b01;
        regWrite_s       = isAluOp_s && (aluCode_s != 4'b1011);
        psren_s          = aluCode_s inside {4'b0101, 4'b1001, 4'b1011};
        pcen_s           = 1'b1;
        nextState_s      = FETCH;
      end
      SHIFT: begin
        bus.chooseResult = 2'b00;
        bus.shiftType    = ext_s[0];
        regWrite_s       = 1'b1;
        pcen_s           = 1'b1;
        nextState_s      = FETCH;
      end
      LOAD_ADDR: begin
        nextState_s = LOAD_WB;
      end
      LOAD_WB: begin
        if (memGo_s) begin
          regWrite_s  = 1'b1;
          pcen_s      = 1'b1;
          nextState_s = FETCH;
        end else begin
          nextState_s = LOAD_WB;
        end
      end
      STORE: begin
        if (memGo_s) begin
          bus.StoreReg = 1'b1;
          memWrite_s   = 1'b1;
          pcen_s       = 1'b1;
          nextState_s  = FETCH;
        end else begin
          nextState_s = STORE;
        end
      end
      BRANCH: begin
        bus.PCinstruction = condMet_s;
        bus.BranchEN      = condMet_s;
        pcen_s            = 1'b1;
        nextState_s       = FETCH;
      end
      JCOND: begin
        bus.jumpEN  = condMet_s;
        bus.SrcB    = condMet_s;
        pcen_s      = 1'b1;
        nextState_s = FETCH;
      end
      JAL: begin
        bus.jalEN        = 1'b1;
        bus.jumpEN       = 1'b1;
        bus.chooseResult = 2'b11;
        regWrite_s       = 1'b1;
        pcen_s           = 1'b1;
        nextState_s      = FETCH;
      end
      default: begin
        nextState_s = FETCH;
      end
    endcase
  end

  // Enables are squashed while reset is high so an abandoned instruction commits nothing.
  assign bus.PCEN            = pcen_s & ~reset;
  assign bus.PSREN           = psren_s & ~reset;
  assign bus.nextInstruction = nextInstr_s & ~reset;
  assign bus.regWrite        = regWrite_s & ~reset;
  assign bus.memWrite        = memWrite_s & ~reset;
  assign state_dbg           = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-instruction cycle plan is built from the
// documented behaviour, expectations are queued, and a negedge monitor compares every cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] stateDbg;

  always #5 clk = ~clk;

  multicycle_controller_if #(.WIDTH(16), .REGBITS(4)) bus ();

  multicycle_controller #(.WIDTH(16), .REGBITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (stateDbg)
  );

`ifdef CTRL_MEM_WAIT_EN
  localparam bit WAITMODE = 1'b1;
`else
  localparam bit WAITMODE = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic pcen, psren, nextI, upd, storeReg, writeData, regWrite, zeroExt;
    logic pcInstr, srcB, shiftType, jumpEN, branchEN, jalEN;
    logic [3:0] aluc;
    logic [1:0] chooseR;
    logic memWrite;
  } outv_t;

  typedef struct {
    outv_t       v;
    logic        mr;
    logic        ld;
    logic        rst;
    logic [15:0] ins;
    logic [7:0]  psr;
  } step_t;

  outv_t expQ[$];
  step_t plan[$];
  int    errors = 0;
  int    checks = 0;
  bit    monOn = 1'b0;

  localparam logic [3:0] S_FETCH = 4'd0, S_LATCH = 4'd1, S_DECODE = 4'd2, S_ALU = 4'd3,
                         S_SHIFT = 4'd4, S_LADDR = 4'd5, S_LWB = 4'd6, S_STORE = 4'd7,
                         S_BRANCH = 4'd8, S_JCOND = 4'd9, S_JAL = 4'd10;

  function automatic outv_t mk(input logic [3:0] st);
    outv_t v;
    v = '0;
    v.st = st;
    return v;
  endfunction

  function automatic bit taken(input logic [3:0] c, input logic [7:0] p);
    bit C, L, F, Z, N;
    C = p[0]; L = p[2]; F = p[5]; Z = p[6]; N = p[7];
    case (c)
      4'h0: return Z;
      4'h1: return !Z;
      4'hD: return N || Z;
      4'h2: return C;
      4'h3: return !C;
      4'h4: return L;
      4'h5: return !L;
      4'hA: return !L && !Z;
      4'hB: return L || Z;
      4'h6: return N;
      4'h7: return !N;
      4'h8: return F;
      4'h9: return !F;
      4'hC: return !N && !Z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic anyMr();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void add(input outv_t v, input logic mr, input logic ld, input logic rst,
                              input logic [15:0] ins, input logic [7:0] psr);
    step_t s;
    s.v = v; s.mr = mr; s.ld = ld; s.rst = rst; s.ins = ins; s.psr = psr;
    plan.push_back(s);
  endfunction

  // Appends the whole cycle-by-cycle expectation for one instruction.
  function automatic void planInstr(input logic [15:0] ins, input logic [7:0] psr,
                                    input int latchStall, input int memStall);
    logic [3:0] op, ext, cond;
    outv_t v;
    bit waitState;
    op = ins[15:12]; cond = ins[11:8]; ext = ins[7:4];
    v = mk(S_FETCH); v.upd = 1'b1;
    add(v, anyMr(), 1'b0, 1'b0, ins, psr);
    if (WAITMODE) begin
      for (int i = 0; i < latchStall; i++) begin
        v = mk(S_LATCH); v.upd = 1'b1;
        add(v, 1'b0, 1'b0, 1'b0, ins, psr);
      end
    end
    v = mk(S_LATCH); v.upd = 1'b1; v.nextI = 1'b1;
    add(v, WAITMODE ? 1'b1 : anyMr(), 1'b0, 1'b0, ins, psr);
    add(mk(S_DECODE), anyMr(), 1'b1, 1'b0, ins, psr);
    waitState = 1'b0;
    if (op == 4'h8) begin
      v = mk(S_SHIFT); v.shiftType = ext[0]; v.regWrite = 1'b1; v.pcen = 1'b1;
    end else if (op == 4'hC) begin
      v = mk(S_BRANCH); v.pcen = 1'b1;
      v.pcInstr = taken(cond, psr); v.branchEN = taken(cond, psr);
    end else if (op == 4'h4 && ext == 4'h0) begin
      add(mk(S_LADDR), anyMr(), 1'b0, 1'b0, ins, psr);
      v = mk(S_LWB); v.regWrite = 1'b1; v.pcen = 1'b1;
      waitState = 1'b1;
    end else if (op == 4'h4 && ext == 4'h4) begin
      v = mk(S_STORE); v.storeReg = 1'b1; v.memWrite = 1'b1; v.pcen = 1'b1;
      waitState = 1'b1;
    end else if (op == 4'h4 && ext == 4'hC) begin
      v = mk(S_JCOND); v.pcen = 1'b1;
      v.jumpEN = taken(cond, psr); v.srcB = taken(cond, psr);
    end else if (op == 4'h4 && ext == 4'h8) begin
      v = mk(S_JAL); v.jalEN = 1'b1; v.jumpEN = 1'b1; v.chooseR = 2'b11;
      v.regWrite = 1'b1; v.pcen = 1'b1;
    end else begin
      bit real_op;
      real_op = (op == 4'h0) || (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF});
      v = mk(S_ALU);
      v.aluc = (op == 4'h0) ? ext : op;
      v.srcB = (op == 4'h0);
      v.zeroExt = (op >= 4'h1 && op <= 4'h3);
      v.chooseR = 2'b01;
      v.regWrite = real_op && (v.aluc != 4'hB);
      v.psren = (v.aluc == 4'h5) || (v.aluc == 4'h9) || (v.aluc == 4'hB);
      v.pcen = 1'b1;
    end
    if (WAITMODE && waitState) begin
      for (int i = 0; i < memStall; i++) begin
        add(mk(v.st), 1'b0, 1'b0, 1'b0, ins, psr);
      end
      add(v, 1'b1, 1'b0, 1'b0, ins, psr);
    end else begin
      add(v, anyMr(), 1'b0, 1'b0, ins, psr);
    end
  endfunction

  task automatic runPlan();
    while (plan.size() > 0) begin
      step_t s;
      s = plan.pop_front();
      if (s.ld) begin
        bus.instr  = s.ins;
        bus.PSROut = s.psr;
      end
      reset         = s.rst;
      bus.mem_ready = s.mr;
      expQ.push_back(s.v);
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every checked cycle compares the DUT outputs against the queued expectation.
  always @(negedge clk) begin
    if (monOn) begin
      outv_t a, e;
      a = {stateDbg, bus.PCEN, bus.PSREN, bus.nextInstruction, bus.updateAddress, bus.StoreReg,
           bus.WriteData, bus.regWrite, bus.ZeroExtend, bus.PCinstruction, bus.SrcB,
           bus.shiftType, bus.jumpEN, bus.BranchEN, bus.jalEN, bus.ALUcond, bus.chooseResult,
           bus.memWrite};
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got=%h required=<nothing queued>", $time, a);
      end else begin
        e = expQ.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL outputs_state%0d t=%0t got=%h required=%h", e.st, $time, a, e);
        end
      end
    end
  end

  initial begin
    outv_t v;
    logic [15:0] ins;
    logic [3:0]  op, ext;
    logic [3:0]  extPick[5];
    bus.instr     = 16'h0000;
    bus.PSROut    = 8'h00;
    bus.mem_ready = 1'b1;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    monOn = 1'b1;

    // Reset state.
    v = mk(S_FETCH); v.upd = 1'b1;
    add(v, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h00);
    runPlan();

    // Directed instructions.
    planInstr(16'h0152, 8'h00, 0, 0);
    planInstr(16'hB305, 8'h40, 1, 0);
    planInstr(16'h4203, 8'h00, 0, 2);
    planInstr(16'hC004, 8'h40, 0, 0);
    planInstr(16'hC004, 8'h00, 0, 0);
    planInstr(16'hCF04, 8'hFF, 0, 0);
    planInstr(16'h4EC0, 8'h00, 0, 0);
    planInstr(16'h4180, 8'h00, 0, 0);
    planInstr(16'h8011, 8'h00, 0, 0);
    planInstr(16'h6123, 8'h00, 0, 0);
    planInstr(16'h4241, 8'h00, 0, 3);
    runPlan();

    // Reset held three cycles starting in LOAD_WB, then a clean instruction.
    planInstr(16'h4203, 8'h00, 0, 0);
    void'(plan.pop_back());
    add(mk(S_LWB), 1'b1, 1'b0, 1'b1, 16'h4203, 8'h00);
    v = mk(S_FETCH); v.upd = 1'b1;
    add(v, 1'b1, 1'b0, 1'b1, 16'h4203, 8'h00);
    add(v, 1'b1, 1'b0, 1'b1, 16'h4203, 8'h00);
    planInstr(16'h0152, 8'h00, 0, 0);
    runPlan();

    // Randomised instruction stream.
    extPick[0] = 4'h0; extPick[1] = 4'h4; extPick[2] = 4'h8; extPick[3] = 4'hC;
    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom_range(0, 15));
      extPick[4] = 4'($urandom_range(0, 15));
      ext = (op == 4'h4) ? extPick[$urandom_range(0, 4)] : 4'($urandom_range(0, 15));
      ins = {op, 4'($urandom_range(0, 15)), ext, 4'($urandom_range(0, 15))};
      planInstr(ins, 8'($urandom_range(0, 255)), $urandom_range(0, 2), $urandom_range(0, 2));
      runPlan();
    end

    monOn = 1'b0;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d required=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
